// File: rtl/rpn_const_eval_pkg.sv
// ============================================================================
// rpn_const_eval_pkg : token/opcode encodings and opcode classifiers
// Revision: 1.0
// ============================================================================
`default_nettype none

package rpn_const_eval_pkg;

  localparam int W_DEFAULT = 32;

  typedef enum logic [1:0] {
    KIND_PUSH  = 2'd0,
    KIND_BINOP = 2'd1,
    KIND_UNOP  = 2'd2,
    KIND_END   = 2'd3
  } kind_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_EQ   = 4'd2,
    OP_NE   = 4'd3,
    OP_GE   = 4'd4,
    OP_GT   = 4'd5,
    OP_LE   = 4'd6,
    OP_LT   = 4'd7,
    OP_LNOT = 4'd8,
    OP_INV  = 4'd9
  } op_e;

  function automatic logic is_unary(input logic [3:0] op);
    return (op == OP_LNOT) || (op == OP_INV);
  endfunction

  function automatic logic is_binary(input logic [3:0] op);
    return (op <= OP_LT);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rpn_const_eval_alu.sv
// ============================================================================
// rpn_const_eval_alu : combinational operator unit shared by BINOP and UNOP
// Revision: 1.0
// ============================================================================
`default_nettype none

module rpn_const_eval_alu
  import rpn_const_eval_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] result,
  output logic         bad_op
);

  localparam logic [W-1:0] C_ZERO = '0;
  localparam logic [W-1:0] C_ONE  = W'(1);

  // Comparisons are signed and yield a zero-extended 0/1.
  always_comb begin
    result = C_ZERO;
    bad_op = 1'b0;
    case (op)
      OP_ADD:  result = a + b;
      OP_SUB:  result = a - b;
      OP_EQ:   result = (a == b) ? C_ONE : C_ZERO;
      OP_NE:   result = (a != b) ? C_ONE : C_ZERO;
      OP_GE:   result = ($signed(a) >= $signed(b)) ? C_ONE : C_ZERO;
      OP_GT:   result = ($signed(a) >  $signed(b)) ? C_ONE : C_ZERO;
      OP_LE:   result = ($signed(a) <= $signed(b)) ? C_ONE : C_ZERO;
      OP_LT:   result = ($signed(a) <  $signed(b)) ? C_ONE : C_ZERO;
      OP_LNOT: result = (a == C_ZERO) ? C_ONE : C_ZERO;
      OP_INV:  result = ~a;
      default: bad_op = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/rpn_const_eval.sv
// ============================================================================
// rpn_const_eval : streaming reverse-Polish constant expression evaluator
// Revision: 1.0
// ============================================================================
`default_nettype none

module rpn_const_eval
  import rpn_const_eval_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [1:0]   in_kind,
  input  logic [3:0]   in_op,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_error
);

  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = $clog2(DEPTH);

  localparam logic [SPW-1:0] C_SP_ZERO = '0;
  localparam logic [SPW-1:0] C_SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] C_SP_TWO  = SPW'(2);
  localparam logic [SPW-1:0] C_SP_FULL = SPW'(DEPTH);

  localparam logic [0:0] ST_ACCEPT = 1'b0;
  localparam logic [0:0] ST_EMIT   = 1'b1;

  logic [0:0]   state;
  logic [SPW-1:0] sp;
  logic         err;
  logic [W-1:0] stack [DEPTH];

  logic [SPW-1:0] sp_m1, sp_m2;
  logic [IW-1:0]  idx_top, idx_next;
  logic [W-1:0]   alu_a, alu_result;
  logic           alu_bad_op;
  logic           tok_err, accept, apply, end_ok;
  logic           wr_en;
  logic [IW-1:0]  wr_idx;
  logic [W-1:0]   wr_data;

  assign sp_m1    = sp - C_SP_ONE;
  assign sp_m2    = sp - C_SP_TWO;
  assign idx_top  = sp_m1[IW-1:0];
  assign idx_next = sp_m2[IW-1:0];

  assign in_ready  = (state == ST_ACCEPT);
  assign out_valid = (state == ST_EMIT);
  assign accept    = in_ready && in_valid;
  assign end_ok    = (sp == C_SP_ONE) && !err;

  // BINOP takes (next, top); UNOP works on top and the b operand is ignored.
  assign alu_a = (in_kind == KIND_BINOP) ? stack[idx_next] : stack[idx_top];

  rpn_const_eval_alu #(.W(W)) u_alu (
    .op     (in_op),
    .a      (alu_a),
    .b      (stack[idx_top]),
    .result (alu_result),
    .bad_op (alu_bad_op)
  );

  always_comb begin
    tok_err = 1'b0;
    case (in_kind)
      KIND_PUSH:  tok_err = (sp == C_SP_FULL);
      KIND_BINOP: tok_err = (sp < C_SP_TWO) || !is_binary(in_op) || alu_bad_op;
      KIND_UNOP:  tok_err = (sp == C_SP_ZERO) || !is_unary(in_op) || alu_bad_op;
      default:    tok_err = 1'b0;
    endcase
  end

  assign apply = accept && !err && !tok_err && (in_kind != KIND_END);

  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = sp[IW-1:0];
    wr_data = in_data;
    if (apply) begin
      case (in_kind)
        KIND_PUSH:  wr_en = 1'b1;
        KIND_BINOP: begin
          wr_en   = 1'b1;
          wr_idx  = idx_next;
          wr_data = alu_result;
        end
        KIND_UNOP: begin
          wr_en   = 1'b1;
          wr_idx  = idx_top;
          wr_data = alu_result;
        end
        default: wr_en = 1'b0;
      endcase
    end
  end

  // Stack contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) stack[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_ACCEPT;
      sp        <= C_SP_ZERO;
      err       <= 1'b0;
      out_data  <= '0;
      out_error <= 1'b0;
    end else if (state == ST_ACCEPT) begin
      if (in_valid) begin
        if (in_kind == KIND_END) begin
          out_data  <= end_ok ? stack[0] : '0;
          out_error <= !end_ok;
          state     <= ST_EMIT;
        end else if (err || tok_err) begin
          err <= 1'b1;
        end else if (in_kind == KIND_PUSH) begin
          sp <= sp + C_SP_ONE;
        end else if (in_kind == KIND_BINOP) begin
          sp <= sp_m1;
        end
      end
    end else if (out_ready) begin
      sp    <= C_SP_ZERO;
      err   <= 1'b0;
      state <= ST_ACCEPT;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rpn_const_eval.sv
// ============================================================================
// tb_rpn_const_eval : scoreboard bench with a queue-based RPN reference model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_rpn_const_eval;
  import rpn_const_eval_pkg::*;

  localparam int DEPTH = 8;
  localparam int W     = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   in_kind = 2'd0;
  logic [3:0]   in_op = 4'd0;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_error;

  rpn_const_eval #(.DEPTH(DEPTH), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_kind   (in_kind),
    .in_op     (in_op),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_error (out_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operand stack as a queue of ints, errors as a sticky flag.
  int        m_stk[$];
  bit        m_err;
  logic [W:0] exp_q[$];   // {error, data}

  function automatic int m_bin(input int op, input int a, input int b);
    case (op)
      0: return a + b;
      1: return a - b;
      2: return (a == b) ? 1 : 0;
      3: return (a != b) ? 1 : 0;
      4: return (a >= b) ? 1 : 0;
      5: return (a >  b) ? 1 : 0;
      6: return (a <= b) ? 1 : 0;
      default: return (a < b) ? 1 : 0;
    endcase
  endfunction

  function automatic void m_clear();
    m_stk.delete();
    m_err = 1'b0;
  endfunction

  function automatic void model_tok(input int kind, input int op, input int data);
    int a, b;
    if (kind == 3) begin
      if (!m_err && m_stk.size() == 1) exp_q.push_back({1'b0, 32'(m_stk[0])});
      else                             exp_q.push_back({1'b1, 32'd0});
      m_clear();
    end else if (!m_err) begin
      if (kind == 0) begin
        if (m_stk.size() == DEPTH) m_err = 1'b1;
        else m_stk.push_back(data);
      end else if (kind == 1) begin
        if (op > 7 || m_stk.size() < 2) m_err = 1'b1;
        else begin
          b = m_stk.pop_back();
          a = m_stk.pop_back();
          m_stk.push_back(m_bin(op, a, b));
        end
      end else begin
        if (!(op == 8 || op == 9) || m_stk.size() < 1) m_err = 1'b1;
        else begin
          a = m_stk.pop_back();
          m_stk.push_back(op == 8 ? ((a == 0) ? 1 : 0) : ~a);
        end
      end
    end
  endfunction

  task automatic send(input int kind, input int op, input logic [W-1:0] data);
    bit ok;
    int n;
    model_tok(kind, op, int'(data));
    in_valid = 1'b1;
    in_kind  = 2'(kind);
    in_op    = 4'(op);
    in_data  = data;
    ok = 1'b0;
    n  = 0;
    while (!ok) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (n > 200) begin
        $display("FAIL handshake_timeout: got in_ready=0 expected 1 at %0t", $time);
        errors++;
        ok = 1'b1;
      end
    end
    in_valid = 1'b0;
    if (kind == 3) chk("end_latency_out_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic push(input logic [W-1:0] d); send(0, 0, d); endtask
  task automatic bin(input int op);           send(1, op, '0); endtask
  task automatic un(input int op);            send(2, op, '0); endtask
  task automatic fin();                       send(3, 0, '0); endtask

  // out_ready driver: random when rand_ready, otherwise forced_ready.
  bit rand_ready   = 1'b0;
  bit forced_ready = 1'b1;
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : forced_ready;
  end

  // Monitor: pop once per presented result, then check it stays stable.
  bit         shown = 1'b0;
  logic [W:0] held;
  always @(negedge clk) begin
    if (rst) begin
      shown = 1'b0;
    end else if (out_valid) begin
      chk("in_ready_low_in_emit", 32'(in_ready), 32'd0);
      if (!shown) begin
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got 0x%0h err=%0b expected none", out_data, out_error);
        end else begin
          held = exp_q.pop_front();
          chk("out_data", out_data, held[W-1:0]);
          chk("out_error", 32'(out_error), 32'(held[W]));
        end
        shown = 1'b1;
      end else begin
        chk("hold_out_data", out_data, held[W-1:0]);
        chk("hold_out_error", 32'(out_error), 32'(held[W]));
      end
      if (out_ready) shown = 1'b0;
    end
  end

  function automatic logic [W-1:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return W'($urandom_range(0, 50));
      2:       return W'($urandom);
      default: return W'(-$urandom_range(1, 50));
    endcase
  endfunction

  initial begin
    int n, k, wait_n;
    m_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_error", 32'(out_error), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    push(42); push(19); bin(OP_ADD); fin();
    push(42); push(19); bin(OP_SUB); fin();
    push(19); push(42); bin(OP_SUB); fin();
    push(42); un(OP_INV); fin();
    push(42); un(OP_LNOT); fin();
    push(0);  un(OP_LNOT); fin();
    for (int op = 2; op <= 7; op++) begin
      push(42); push(19); bin(op); fin();
    end
    push(32'hFFFF_FFFF); push(0); bin(OP_LT); fin();
    push(5); bin(OP_ADD); fin();
    for (int i = 0; i < 9; i++) push(32'(i + 1));
    fin();
    for (int i = 0; i < 8; i++) push(32'(i + 1));
    for (int i = 0; i < 7; i++) bin(OP_ADD);
    fin();
    push(1); push(2); fin();
    push(3); bin(OP_LNOT); fin();
    push(3); un(OP_ADD); fin();
    push(3); push(4); bin(12); fin();

    // Backpressure: result must hold for 5 cycles, then a clean expression.
    forced_ready = 1'b0;
    push(42); push(19); bin(OP_ADD); fin();
    repeat (5) @(posedge clk);
    #1;
    chk("bp_out_valid_held", 32'(out_valid), 32'd1);
    forced_ready = 1'b1;
    push(7); un(OP_LNOT); fin();

    // Reset mid-expression.
    push(42); push(19);
    rst = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_error", 32'(out_error), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_clear();
    push(1); fin();

    // Reset while a nonzero result is held in EMIT.
    forced_ready = 1'b0;
    push(77); fin();
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_emit_out_valid", 32'(out_valid), 32'd0);
    chk("rst_emit_out_data", out_data, 32'd0);
    chk("rst_emit_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_clear();
    forced_ready = 1'b1;
    push(2); push(3); bin(OP_GT); fin();

    // Random expressions with random backpressure.
    rand_ready = 1'b1;
    for (int e = 0; e < 250; e++) begin
      n = $urandom_range(1, 12);
      for (int t = 0; t < n; t++) begin
        k = $urandom_range(0, 19);
        if (k < 10)      push(rand_data());
        else if (k < 15) bin(($urandom_range(0, 9) != 0) ? $urandom_range(0, 7) : $urandom_range(8, 15));
        else             un(($urandom_range(0, 9) != 0) ? $urandom_range(8, 9) : $urandom_range(0, 15));
      end
      fin();
    end
    rand_ready = 1'b0;
    forced_ready = 1'b1;

    wait_n = 0;
    while ((exp_q.size() != 0 || out_valid) && wait_n < 200) begin
      @(posedge clk);
      wait_n++;
    end
    @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rpn_const_eval.md
# rpn_const_eval

Sequential evaluator for 32-bit constant integer expressions, streamed in as reverse-Polish tokens. It supports the elaboration-time operator set: binary `+ - == != >= > <= <` and unary `! ~`. It sits directly upstream of parameter consumers: each finished expression yields one result word, which downstream logic latches as a parameter-like constant (e.g. a signal initial value). Malformed expressions are flagged, never silently truncated.

## Interface
- `DEPTH`, 8: operand stack entries; must be ≥2.
- `W`, 32: data width; operands are signed two's complement.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: token valid.
- `in_ready` out 1: token accepted when `in_valid && in_ready`.
- `in_kind` in 2: token kind. 0 = PUSH, 1 = BINOP, 2 = UNOP, 3 = END.
- `in_op` in 4: opcode for BINOP/UNOP.
  - ADD 0, SUB 1, EQ 2, NE 3, GE 4, GT 5, LE 6, LT 7
  - LNOT 8, INV 9
- `in_data` in W: literal for PUSH.
- `out_valid` out 1: result valid.
- `out_ready` in 1: result consumed when `out_valid && out_ready`.
- `out_data` out W: expression result.
- `out_error` out 1: expression malformed; `out_data` is 0 when set.

## Operation
- States:
  - ACCEPT: `in_ready` = 1.
  - EMIT: `in_ready` = 0, `out_valid` = 1.
- ACCEPT, one token per handshake:
  - PUSH: `stack[sp] <= in_data`, `sp++`. If `sp == DEPTH`, set `err`; stack unchanged.
  - BINOP: needs `sp ≥ 2`. `stack[sp-2] <= stack[sp-2] op stack[sp-1]`, `sp--`.
  - UNOP: needs `sp ≥ 1`. `stack[sp-1] <= op(stack[sp-1])`.
  - END: load `out_data`/`out_error`, then go to EMIT.
    - If `sp == 1` and `!err`: `out_data` = `stack[0]`, `out_error` = 0.
    - Otherwise: `out_data` = 0, `out_error` = 1.
- Error rules:
  - Underflow sets `err`.
  - A unary opcode under BINOP, a binary opcode under UNOP, or opcodes 10–15 set `err`.
  - `err` is sticky until END. After `err` is set, tokens are consumed but the stack is not modified.
- EMIT: hold `out_valid`/`out_data`/`out_error` stable until `out_ready`. On handshake: `sp <= 0`, `err <= 0`, return to ACCEPT.
- Arithmetic:
  - ADD/SUB wrap modulo 2^W.
  - Comparisons are signed and produce zero-extended 0/1.
  - LNOT gives 1 if the operand is 0, else 0.
  - INV is bitwise complement.

## Timing
- Reset (async assert, clear on the clock edge) gives:
  - state ACCEPT, `sp` = 0, `err` = 0
  - `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_error` = 0
  - stack contents don't-care
- One token per cycle, no bubbles. The ALU result is written in the same cycle the token is accepted.
- Latency: END accepted at edge n → `out_valid` high after edge n, visible in cycle n+1.
- Minimum repetition: one expression per (tokens + 1) cycles when `out_ready` = 1. Accepting the next token and retiring EMIT in the same cycle is not allowed; `in_ready` is low throughout EMIT.
- `in_ready` depends only on state, never on `in_valid` or `out_ready`.
- Reset mid-expression or mid-EMIT discards everything; no partial output.
- Overflow and underflow on the same token cannot both occur; a single `err` bit covers both.

## Structure
- Package `rpn_const_eval_pkg` holds:
  - `kind_e` and `op_e` enums with the encodings above
  - `is_unary(op)` and `is_binary(op)` functions
  - localparam default `W`
- Sub-module `rpn_const_eval_alu`, purely combinational: `(op, a, b) → result, bad_op`. It is shared by the BINOP and UNOP paths; UNOP ignores `b`.
- The top holds the FSM, the stack register array, `sp` (`$clog2(DEPTH+1)` bits) and `err`.

## Test plan
- PUSH 42, PUSH 19, BINOP ADD, END → `out_data` = 61, `out_error` = 0, `out_valid` one cycle after END.
- 42 19 SUB → 23; 19 42 SUB → 4294967273; 42 INV → 4294967253; 42 LNOT → 0; 0 LNOT → 1.
- 42 19 with each comparison EQ/NE/GE/GT/LE/LT → 0/1/1/1/0/0. Signed check: 0xFFFFFFFF 0 LT → 1.
- Errors:
  - PUSH 5, BINOP ADD, END → `out_error` = 1, `out_data` = 0.
  - 9 PUSHes at DEPTH = 8, END → `out_error` = 1.
  - PUSH 1, PUSH 2, END → `out_error` = 1.
  - PUSH 3, BINOP LNOT, END → `out_error` = 1.
- Backpressure: hold `out_ready` = 0 for 5 cycles → `out_valid`/`out_data` stable and `in_ready` = 0. Release → next expression (7 LNOT → 0) evaluates correctly with cleared `err`.
- Assert `rst` after PUSH 42, PUSH 19 → all outputs at reset values immediately. A following PUSH 1, END → 1, showing the stack was cleared.
